// File: rtl/sm_dbg_pkg.sv
// Shared encodings for the schoolRISCV debug/run controller: host commands,
// controller states and register-file geometry.
package sm_dbg_pkg;

    localparam logic [1:0] SM_DBG_RUN  = 2'b00;
    localparam logic [1:0] SM_DBG_HALT = 2'b01;
    localparam logic [1:0] SM_DBG_STEP = 2'b10;
    localparam logic [1:0] SM_DBG_DUMP = 2'b11;

    localparam logic [1:0] ST_HALT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_STEP = 2'd2;
    localparam logic [1:0] ST_DUMP = 2'd3;

    localparam int         REG_COUNT = 32;
    localparam logic [4:0] REG_LAST  = 5'd31;

    function automatic logic cpuActive(input logic [1:0] st);
        return (st == ST_RUN) || (st == ST_STEP);
    endfunction

endpackage

// File: rtl/sm_dbg_dump.sv
// Register-dump engine: walks registers 0..31 as a valid/ready beat stream and
// pulses done as the last beat is consumed.
module sm_dbg_dump
    import sm_dbg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        dumpReady,
    input  logic [31:0] regData,
    output logic [4:0]  dumpPtr,
    output logic        dumpValid,
    output logic [4:0]  dumpAddr,
    output logic [31:0] dumpData,
    output logic        done
);

    logic beat;

    assign beat     = dumpValid & dumpReady;
    assign done     = beat & (dumpPtr == REG_LAST);
    assign dumpAddr = dumpPtr;
    // The CPU is frozen during a dump, so the async read stays stable while stalled.
    assign dumpData = regData;

    // NOTE: sequential state is assigned with <= only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dumpPtr   <= 5'd0;
            dumpValid <= 1'b0;
        end else if (start) begin
            dumpPtr   <= 5'd0;
            dumpValid <= 1'b1;
        end else if (beat) begin
            dumpPtr <= dumpPtr + 5'd1;
            if (dumpPtr == REG_LAST) dumpValid <= 1'b0;
        end
    end

endmodule

// File: rtl/sm_dbg_ctrl.sv
// Debug/run controller for schoolRISCV: run/halt/step sequencing, register dump,
// cycle profiling. Optional breakpoint unit enabled by SM_DBG_BREAKPOINT_EN.
module sm_dbg_ctrl
    import sm_dbg_pkg::*;
#(
    parameter int STEP_W       = 8,
    parameter int CNT_W        = 32,
    parameter int RUN_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmdValid,
    output logic              cmdReady,
    input  logic [1:0]        cmdOp,
    input  logic [STEP_W-1:0] cmdArg,
    output logic              cpuEn,
    output logic [4:0]        regAddr,
    input  logic [31:0]       regData,
    input  logic [4:0]        monAddr,
    output logic [31:0]       monData,
    output logic              dumpValid,
    input  logic              dumpReady,
    output logic [4:0]        dumpAddr,
    output logic [31:0]       dumpData,
    output logic              halted,
`ifdef SM_DBG_BREAKPOINT_EN
    input  logic              bpEnable,
    input  logic [31:0]       bpAddr,
    input  logic [31:0]       cpuPc,
    output logic              bpHit,
`endif
    output logic [CNT_W-1:0]  runCycles
);

    localparam logic [1:0] ST_RESET = (RUN_ON_RESET != 0) ? ST_RUN : ST_HALT;

    logic [1:0]        state, stateNext;
    logic [STEP_W-1:0] stepCnt, stepCntNext;
    logic              cpuEnQ;
    logic              accept;
    logic              bpMatch;
    logic              dumpStart;
    logic              dumpDone;
    logic [4:0]        dumpPtr;

    assign cmdReady  = (state == ST_HALT) || (state == ST_RUN);
    assign accept    = cmdValid & cmdReady;
    assign dumpStart = accept && (cmdOp == SM_DBG_DUMP);
    assign halted    = (state == ST_HALT);
    assign regAddr   = (state == ST_DUMP) ? dumpPtr : monAddr;
    assign monData   = regData;

`ifdef SM_DBG_BREAKPOINT_EN
    logic bpSkip;

    // The first enabled cycle after a halt skips the compare so we can leave a breakpoint.
    assign bpMatch = bpEnable & (cpuPc == bpAddr) & cpuEnQ & ~bpSkip;
    assign cpuEn   = cpuEnQ & ~bpMatch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpSkip <= 1'b1;
            bpHit  <= 1'b0;
        end else begin
            bpSkip <= ~cpuEnQ;
            if (accept)       bpHit <= 1'b0;
            else if (bpMatch) bpHit <= 1'b1;
        end
    end
`else
    assign bpMatch = 1'b0;
    assign cpuEn   = cpuEnQ;
`endif

    // NOTE: every output of this block gets a default first so no path infers a latch.
    always_comb begin
        stateNext   = state;
        stepCntNext = stepCnt;
        case (state)
            ST_HALT, ST_RUN: begin
                if (accept) begin
                    case (cmdOp)
                        SM_DBG_RUN:  stateNext = ST_RUN;
                        SM_DBG_HALT: stateNext = ST_HALT;
                        SM_DBG_STEP: begin
                            stateNext   = ST_STEP;
                            stepCntNext = (cmdArg == '0) ? STEP_W'(1) : cmdArg;
                        end
                        SM_DBG_DUMP: stateNext = ST_DUMP;
                    endcase
                end else if (bpMatch) begin
                    stateNext = ST_HALT;
                end
            end
            ST_STEP: begin
                if (bpMatch || stepCnt <= STEP_W'(1)) begin
                    stateNext   = ST_HALT;
                    stepCntNext = '0;
                end else begin
                    stepCntNext = stepCnt - STEP_W'(1);
                end
            end
            ST_DUMP: if (dumpDone) stateNext = ST_HALT;
            default: stateNext = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RESET;
            stepCnt   <= '0;
            cpuEnQ    <= cpuActive(ST_RESET);
            runCycles <= '0;
        end else begin
            state   <= stateNext;
            stepCnt <= stepCntNext;
            cpuEnQ  <= cpuActive(stateNext);
            if (cpuEn) runCycles <= runCycles + CNT_W'(1);
        end
    end

    sm_dbg_dump u_dump (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (dumpStart),
        .dumpReady (dumpReady),
        .regData   (regData),
        .dumpPtr   (dumpPtr),
        .dumpValid (dumpValid),
        .dumpAddr  (dumpAddr),
        .dumpData  (dumpData),
        .done      (dumpDone)
    );

endmodule

// File: tb/tb_sm_dbg_ctrl.sv
// Scoreboard bench for sm_dbg_ctrl; breakpoint checks run when SM_DBG_BREAKPOINT_EN is defined.
module tb_sm_dbg_ctrl;
    import sm_dbg_pkg::*;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        cmdValid = 1'b0;
    logic        cmdReady;
    logic [1:0]  cmdOp = 2'b00;
    logic [7:0]  cmdArg = 8'd0;
    logic        cpuEn;
    logic [4:0]  regAddr;
    logic [31:0] regData;
    logic [4:0]  monAddr = 5'd0;
    logic [31:0] monData;
    logic        dumpValid;
    logic        dumpReady = 1'b0;
    logic [4:0]  dumpAddr;
    logic [31:0] dumpData;
    logic        halted;
    logic [31:0] runCycles;
`ifdef SM_DBG_BREAKPOINT_EN
    logic        bpEnable = 1'b0;
    logic [31:0] bpAddr = 32'h0;
    logic [31:0] cpuPc;
    logic        bpHit;
`endif

    int    nChecks = 0;
    int    nFails = 0;
    int    beatCount = 0;
    bit    toggleEn = 1'b0;
    beat_t sbQ[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] regVal(input logic [4:0] a);
        return 32'h5A00_0000 + (32'(a) * 32'h0001_0101);
    endfunction

    assign regData = regVal(regAddr);

    sm_dbg_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmdValid  (cmdValid),
        .cmdReady  (cmdReady),
        .cmdOp     (cmdOp),
        .cmdArg    (cmdArg),
        .cpuEn     (cpuEn),
        .regAddr   (regAddr),
        .regData   (regData),
        .monAddr   (monAddr),
        .monData   (monData),
        .dumpValid (dumpValid),
        .dumpReady (dumpReady),
        .dumpAddr  (dumpAddr),
        .dumpData  (dumpData),
        .halted    (halted),
`ifdef SM_DBG_BREAKPOINT_EN
        .bpEnable  (bpEnable),
        .bpAddr    (bpAddr),
        .cpuPc     (cpuPc),
        .bpHit     (bpHit),
`endif
        .runCycles (runCycles)
    );

`ifdef SM_DBG_BREAKPOINT_EN
    // Minimal CPU model: PC advances by one instruction on every enabled edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)     cpuPc <= 32'h0;
        else if (cpuEn) cpuPc <= cpuPc + 32'd4;
    end
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sendCmd(input logic [1:0] op, input logic [7:0] arg);
        check("cmd_ready_before_accept", {31'b0, cmdReady}, 32'd1);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdArg   = arg;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic countEn(input int n, output int hi, output int rdyLow);
        hi = 0;
        rdyLow = 0;
        for (int i = 0; i < n; i++) begin
            if (cpuEn) begin
                hi++;
                if (!cmdReady) rdyLow++;
            end
            tick();
        end
    endtask

    // dumpReady pattern generator, alternating 1/0 while enabled.
    initial forever begin
        @(posedge clk);
        #1;
        if (toggleEn) dumpReady = ~dumpReady;
    end

    // Monitor: every presented dump beat is compared against the scoreboard head,
    // including stalled cycles, so data must hold until consumed.
    initial forever begin
        @(negedge clk);
        if (rst_n && dumpValid) begin
            if (sbQ.size() == 0) begin
                check("dump_unexpected_beat", {31'b0, dumpValid}, 32'd0);
            end else begin
                check("dump_addr", {27'b0, dumpAddr}, {27'b0, sbQ[0].addr});
                check("dump_data", dumpData, sbQ[0].data);
                check("dump_regaddr", {27'b0, regAddr}, {27'b0, sbQ[0].addr});
                if (dumpReady) begin
                    void'(sbQ.pop_front());
                    beatCount++;
                end
            end
        end
    end

    initial begin
        int hi, rdyLow, acceptIdx;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_cpuEn", {31'b0, cpuEn}, 32'd1);
        check("rst_cmdReady", {31'b0, cmdReady}, 32'd1);
        check("rst_halted", {31'b0, halted}, 32'd0);
        check("rst_dumpValid", {31'b0, dumpValid}, 32'd0);
        check("rst_runCycles", runCycles, 32'd0);
        tick();
        rst_n = 1'b1;

        // Free run, then HALT
        repeat (10) tick();
        check("run_cpuEn", {31'b0, cpuEn}, 32'd1);
        check("run_cycles_10", runCycles, 32'd10);
        sendCmd(SM_DBG_HALT, 8'd0);
        check("halt_cpuEn", {31'b0, cpuEn}, 32'd0);
        check("halt_halted", {31'b0, halted}, 32'd1);
        check("halt_cycles_11", runCycles, 32'd11);
        repeat (3) tick();
        check("halt_cycles_frozen", runCycles, 32'd11);

        // STEP 3 and STEP 0 from HALT
        sendCmd(SM_DBG_STEP, 8'd3);
        countEn(8, hi, rdyLow);
        check("step3_en_cycles", 32'(hi), 32'd3);
        check("step3_ready_low", 32'(rdyLow), 32'd3);
        check("step3_halted", {31'b0, halted}, 32'd1);
        check("step3_cycles", runCycles, 32'd14);
        sendCmd(SM_DBG_STEP, 8'd0);
        countEn(5, hi, rdyLow);
        check("step0_en_cycles", 32'(hi), 32'd1);
        check("step0_cycles", runCycles, 32'd15);

        // DUMP from RUN with a stalling consumer
        sendCmd(SM_DBG_RUN, 8'd0);
        check("run2_cpuEn", {31'b0, cpuEn}, 32'd1);
        monAddr = 5'd10;
        for (int i = 0; i < REG_COUNT; i++) sbQ.push_back('{addr: 5'(i), data: regVal(5'(i))});
        beatCount = 0;
        toggleEn  = 1'b1;
        sendCmd(SM_DBG_DUMP, 8'd0);
        check("dump_cpuEn", {31'b0, cpuEn}, 32'd0);
        check("dump_cmdReady", {31'b0, cmdReady}, 32'd0);
        check("dump_regaddr_start", {27'b0, regAddr}, 32'd0);
        for (int i = 0; i < 200 && !halted; i++) tick();
        toggleEn  = 1'b0;
        dumpReady = 1'b0;
        check("dump_done_halted", {31'b0, halted}, 32'd1);
        check("dump_beats", 32'(beatCount), 32'd32);
        check("dump_sb_empty", 32'(sbQ.size()), 32'd0);
        check("dump_valid_clear", {31'b0, dumpValid}, 32'd0);
        check("post_dump_regaddr", {27'b0, regAddr}, 32'd10);
        check("post_dump_mondata", monData, 32'h5A0A_0A0A);
        check("post_dump_cycles", runCycles, 32'd16);

        // RUN held during STEP 5 stalls and is accepted once the step completes
        cmdValid = 1'b1;
        cmdOp    = SM_DBG_STEP;
        cmdArg   = 8'd5;
        tick();
        cmdOp     = SM_DBG_RUN;
        cmdArg    = 8'd0;
        acceptIdx = -1;
        hi        = 0;
        for (int i = 0; i < 20 && acceptIdx < 0; i++) begin
            if (cmdReady) acceptIdx = i;
            else if (cpuEn) hi++;
            tick();
        end
        cmdValid = 1'b0;
        check("stall_accept_cycle", 32'(acceptIdx), 32'd5);
        check("stall_step_en", 32'(hi), 32'd5);
        check("stall_run_cpuEn", {31'b0, cpuEn}, 32'd1);
        check("stall_run_halted", {31'b0, halted}, 32'd0);
        check("stall_cycles", runCycles, 32'd21);

        // STEP accepted in RUN restarts the count
        sendCmd(SM_DBG_STEP, 8'd2);
        countEn(6, hi, rdyLow);
        check("step_in_run_en", 32'(hi), 32'd2);
        check("step_in_run_halted", {31'b0, halted}, 32'd1);
        check("step_in_run_cycles", runCycles, 32'd24);

        // Reset in mid-dump aborts to reset values
        dumpReady = 1'b1;
        for (int i = 0; i < REG_COUNT; i++) sbQ.push_back('{addr: 5'(i), data: regVal(5'(i))});
        sendCmd(SM_DBG_DUMP, 8'd0);
        repeat (4) tick();
        rst_n = 1'b0;
`ifdef SM_DBG_BREAKPOINT_EN
        bpAddr   = 32'h0000_000c;
        bpEnable = 1'b1;
`endif
        #1;
        sbQ.delete();
        dumpReady = 1'b0;
        check("abort_dumpValid", {31'b0, dumpValid}, 32'd0);
        check("abort_halted", {31'b0, halted}, 32'd0);
        check("abort_cmdReady", {31'b0, cmdReady}, 32'd1);
        check("abort_cycles", runCycles, 32'd0);
        check("abort_regaddr", {27'b0, regAddr}, 32'd10);
        tick();
        rst_n = 1'b1;
        tick();
        check("after_abort_cycles", runCycles, 32'd1);

`ifdef SM_DBG_BREAKPOINT_EN
        // Breakpoint at 0x0c stops the CPU before it executes
        for (int i = 0; i < 20 && !halted; i++) tick();
        check("bp_halted", {31'b0, halted}, 32'd1);
        check("bp_pc", cpuPc, 32'h0000_000c);
        check("bp_hit", {31'b0, bpHit}, 32'd1);
        sendCmd(SM_DBG_RUN, 8'd0);
        check("bp_hit_clear", {31'b0, bpHit}, 32'd0);
        repeat (3) tick();
        check("bp_resume_halted", {31'b0, halted}, 32'd0);
        check("bp_resume_pc", cpuPc, 32'h0000_0018);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
